// File: rtl/hdc_class_search_ctrl.sv
// hdc_class_search_ctrl: loads a query hypervector, sweeps the class ROM and reports the nearest class by Hamming distance.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a query (honoured in IDLE only)
//   query_frame/valid/ready  query frame stream, frames 0..NUM_FRAMES-1 in order
//   frame_id, frame_index    class ROM address (class, frame)
//   class_vec_in             class ROM data, combinational from the address
//   busy, done               activity flag, one-cycle result strobe
//   pred_class, pred_dist    argmin class and its distance, held between results
module hdc_class_search_ctrl #(
    parameter int FRAME_W     = 64,
    parameter int NUM_FRAMES  = 3,
    parameter int NUM_CLASSES = 8,
    parameter int CLASS_ID_W  = 3,
    parameter int FRAME_IDX_W = 2,
    parameter int DIST_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [FRAME_W-1:0]     query_frame,
    input  logic                   query_valid,
    output logic                   query_ready,
    output logic [CLASS_ID_W-1:0]  frame_id,
    output logic [FRAME_IDX_W-1:0] frame_index,
    input  logic [FRAME_W-1:0]     class_vec_in,
    output logic                   busy,
    output logic                   done,
    output logic [CLASS_ID_W-1:0]  pred_class,
    output logic [DIST_W-1:0]      pred_dist
);
    typedef enum logic [2:0] {IDLE, LOAD, SWEEP, DRAIN, DONE} state_t;
    localparam logic [FRAME_IDX_W-1:0] F_LAST = FRAME_IDX_W'(NUM_FRAMES - 1);
    localparam logic [CLASS_ID_W-1:0]  C_LAST = CLASS_ID_W'(NUM_CLASSES - 1);
    state_t                 state;
    logic [FRAME_W-1:0]     qbuf [NUM_FRAMES];
    logic [FRAME_IDX_W-1:0] load_cnt;
    logic                   s1_valid;
    logic                   s1_last;
    logic [DIST_W-1:0]      s1_pc;
    logic [CLASS_ID_W-1:0]  s1_tag;
    logic [DIST_W-1:0]      acc;
    logic [DIST_W-1:0]      best_dist;
    logic [CLASS_ID_W-1:0]  best_class;
    logic [DIST_W-1:0]      pc;
    logic [DIST_W-1:0]      sum;
    logic                   better;
    logic [DIST_W-1:0]      acc_n;
    logic [DIST_W-1:0]      best_dist_n;
    logic [CLASS_ID_W-1:0]  best_class_n;
    // Stage 1 input: Hamming distance of the addressed query frame against ROM data.
    assign pc = DIST_W'($countones(qbuf[frame_index] ^ class_vec_in));
    // Stage 2: accumulate per class; strict compare keeps the lower class id on ties.
    always_comb begin
        sum          = acc + s1_pc;
        better       = s1_valid && s1_last && (sum < best_dist);
        acc_n        = s1_valid ? (s1_last ? '0 : sum) : acc;
        best_dist_n  = better ? sum : best_dist;
        best_class_n = better ? s1_tag : best_class;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            load_cnt    <= '0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_pc       <= '0;
            s1_tag      <= '0;
            acc         <= '0;
            best_dist   <= '0;
            best_class  <= '0;
            query_ready <= 1'b0;
            frame_id    <= '0;
            frame_index <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pred_class  <= '0;
            pred_dist   <= '0;
            for (int i = 0; i < NUM_FRAMES; i++) qbuf[i] <= '0;
        end else begin
            done       <= 1'b0;
            s1_valid   <= state == SWEEP;
            s1_pc      <= pc;
            s1_tag     <= frame_id;
            s1_last    <= frame_index == F_LAST;
            acc        <= acc_n;
            best_dist  <= best_dist_n;
            best_class <= best_class_n;
            case (state)
                IDLE: if (start) begin
                    state       <= LOAD;
                    busy        <= 1'b1;
                    query_ready <= 1'b1;
                    load_cnt    <= '0;
                    acc         <= '0;
                    best_dist   <= '1;
                    best_class  <= '0;
                end
                LOAD: if (query_valid && query_ready) begin
                    qbuf[load_cnt] <= query_frame;
                    load_cnt       <= load_cnt + 1'b1;
                    if (load_cnt == F_LAST) begin
                        state       <= SWEEP;
                        query_ready <= 1'b0;
                        frame_id    <= '0;
                        frame_index <= '0;
                    end
                end
                SWEEP: begin
                    // Row-major walk: frame index first, then class.
                    frame_index <= (frame_index == F_LAST) ? '0 : frame_index + 1'b1;
                    if (frame_index == F_LAST) begin
                        frame_id <= (frame_id == C_LAST) ? '0 : frame_id + 1'b1;
                        if (frame_id == C_LAST) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Final entry retires this cycle, so take the post-update best values.
                    state      <= DONE;
                    done       <= 1'b1;
                    pred_class <= best_class_n;
                    pred_dist  <= best_dist_n;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
